// File: rtl/mips_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_trace_pkg
// Description : Shared types for the MIPS trace buffer. It defines the
//               capture FSM state encoding, the layout of one trace entry
//               and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_trace_pkg;

    // Width of one stored sample: {pc, od, alu}
    localparam int TRACE_W = 96;

    // Capture FSM state codes; these are also visible on state_o
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    // One trace record; pc occupies the most significant word
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] od;
        logic [31:0] alu;
    } trace_entry_t;

    // Eight-bit increment that sticks at 255 rather than wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_trace_buffer_if
// Description : Drain port of the trace buffer. It is a show-ahead
//               valid/ready stream that carries the head trace entry. The
//               trace buffer uses the master modport and the consumer uses
//               the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_trace_buffer_if;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_od;
    logic [31:0] out_alu;

    modport master (
        output out_valid,
        output out_pc,
        output out_od,
        output out_alu,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_od,
        input  out_alu,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/mips_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mips_trace_fifo
// Description : Show-ahead FIFO of trace entries. DEPTH must be a power of
//               two, so the pointers wrap naturally. The count register has
//               one extra MSB so that it can represent a full FIFO. If a
//               push arrives while the FIFO is full, it is accepted only
//               when a pop occurs on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_clear,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire trace_entry_t           i_data,
    output trace_entry_t                o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

    trace_entry_t        r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_count;

    logic                w_do_pop;
    logic                w_do_push;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    // A pop makes room in the same cycle, so a full FIFO can still accept a push
    assign w_do_pop  = i_pop && !o_empty && !i_clear;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !i_clear;

    // The head is read straight from storage; when the FIFO is empty the output is forced to zero
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; it has no reset because the pointers define which entries are valid
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; a clear flushes the FIFO without touching storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mips_trace_buffer
// Description : Passive observer of the single-cycle MIPS core. After the
//               core PC matches trig_pc, it captures POST_N samples of
//               {pc, od, alu_c} into a show-ahead FIFO. The samples are
//               drained over a valid/ready interface. A sample that arrives
//               while the FIFO is full is dropped, and the drop is reported
//               on the sticky overflow flag and the saturating dropped count.
// Config      : TRACE_DEDUP_EN - when defined, a RUN sample whose pc equals
//               the previously pushed pc is skipped. The skipped sample does
//               not count toward POST_N. This filters out stall and
//               self-loop repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int POST_N = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   clear,
    input  wire logic                   arm,
    input  wire logic [31:0]            trig_pc,
    input  wire logic [31:0]            pc,
    input  wire logic [31:0]            od,
    input  wire logic [31:0]            alu_c,
    mips_trace_buffer_if.master         drain,
    output logic [$clog2(DEPTH):0]      count,
    output logic [1:0]                  state_o,
    output logic                        overflow,
    output logic [7:0]                  dropped
);

    // After the trigger sample, this many samples remain to be captured
    localparam logic [7:0] c_POST_M1 = 8'(POST_N - 1);

    trace_state_e        r_state;
    trace_state_e        w_state_nxt;
    logic [7:0]          r_rem;
    logic [7:0]          w_rem_nxt;
    logic                r_overflow;
    logic [7:0]          r_dropped;

    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_dup;
    logic                w_full;
    logic                w_empty;
    trace_entry_t        w_sample;
    trace_entry_t        w_head;

    assign w_sample = '{pc: pc, od: od, alu: alu_c};

`ifdef TRACE_DEDUP_EN
    logic [31:0]         r_last_pc;

    // Record the pc of every attempted push, so that RUN can skip back-to-back repeats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_pc <= '0;
        end else if (w_push) begin
            r_last_pc <= pc;
        end
    end

    assign w_dup = (pc == r_last_pc);
`else
    assign w_dup = 1'b0;
`endif

    // Capture FSM state and post-trigger countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next-state logic and push decision; clear overrides both arm and trigger
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_push      = 1'b0;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        w_state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (pc == trig_pc) begin
                        w_push      = 1'b1;
                        w_rem_nxt   = c_POST_M1;
                        w_state_nxt = (c_POST_M1 == 8'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (!w_dup) begin
                        w_push    = 1'b1;
                        w_rem_nxt = r_rem - 8'd1;
                        if (r_rem == 8'd1) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        w_state_nxt = ARMED;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // A push while full is lost unless a pop on the same edge frees a slot
    assign w_pop  = !w_empty && drain.out_ready;
    assign w_drop = w_push && w_full && !w_pop;

    // Overflow reporting: a sticky flag plus a saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_dropped  <= sat_inc8(r_dropped);
        end
    end

    mips_trace_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_clear (clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_sample),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign drain.out_valid = !w_empty;
    assign drain.out_pc    = w_head.pc;
    assign drain.out_od    = w_head.od;
    assign drain.out_alu   = w_head.alu;

    assign state_o  = r_state;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_mips_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_trace_buffer
// Description : Self-checking bench with three instances that share one
//               stimulus stream: A (DEPTH 16, POST_N 8), B (DEPTH 4,
//               POST_N 8) and C (DEPTH 2, POST_N 1). A reference model holds
//               each instance's FIFO as a plain list and is checked every
//               cycle. A directed table and a few hand-written sequences add
//               fixed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_trace_buffer;

    logic        clk = 1'b0;
    logic        reset, clear, arm;
    logic [31:0] trig_pc, pc, od, alu;
    logic [2:0]  rdy;

    always #5 clk = ~clk;

    mips_trace_buffer_if if_a ();
    mips_trace_buffer_if if_b ();
    mips_trace_buffer_if if_c ();

    assign if_a.out_ready = rdy[0];
    assign if_b.out_ready = rdy[1];
    assign if_c.out_ready = rdy[2];

    logic [4:0] cnt_a;
    logic [2:0] cnt_b;
    logic [1:0] cnt_c;
    logic [1:0] st_a, st_b, st_c;
    logic       ov_a, ov_b, ov_c;
    logic [7:0] dr_a, dr_b, dr_c;

    mips_trace_buffer #(.DEPTH(16), .POST_N(8)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .arm(arm), .trig_pc(trig_pc),
        .pc(pc), .od(od), .alu_c(alu), .drain(if_a), .count(cnt_a),
        .state_o(st_a), .overflow(ov_a), .dropped(dr_a));
    mips_trace_buffer #(.DEPTH(4), .POST_N(8)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .arm(arm), .trig_pc(trig_pc),
        .pc(pc), .od(od), .alu_c(alu), .drain(if_b), .count(cnt_b),
        .state_o(st_b), .overflow(ov_b), .dropped(dr_b));
    mips_trace_buffer #(.DEPTH(2), .POST_N(1)) u_c (
        .clk(clk), .reset(reset), .clear(clear), .arm(arm), .trig_pc(trig_pc),
        .pc(pc), .od(od), .alu_c(alu), .drain(if_c), .count(cnt_c),
        .state_o(st_c), .overflow(ov_c), .dropped(dr_c));

    // Actual outputs gathered per instance index
    logic [31:0] a_cnt [3];
    logic [31:0] a_st  [3];
    logic [31:0] a_ov  [3];
    logic [31:0] a_dr  [3];
    logic [31:0] a_vld [3];
    logic [31:0] a_pc  [3];
    logic [31:0] a_od  [3];
    logic [31:0] a_alu [3];

    assign a_cnt[0] = 32'(cnt_a);  assign a_cnt[1] = 32'(cnt_b);  assign a_cnt[2] = 32'(cnt_c);
    assign a_st[0]  = 32'(st_a);   assign a_st[1]  = 32'(st_b);   assign a_st[2]  = 32'(st_c);
    assign a_ov[0]  = 32'(ov_a);   assign a_ov[1]  = 32'(ov_b);   assign a_ov[2]  = 32'(ov_c);
    assign a_dr[0]  = 32'(dr_a);   assign a_dr[1]  = 32'(dr_b);   assign a_dr[2]  = 32'(dr_c);
    assign a_vld[0] = 32'(if_a.out_valid);
    assign a_vld[1] = 32'(if_b.out_valid);
    assign a_vld[2] = 32'(if_c.out_valid);
    assign a_pc[0]  = if_a.out_pc;  assign a_pc[1]  = if_b.out_pc;  assign a_pc[2]  = if_c.out_pc;
    assign a_od[0]  = if_a.out_od;  assign a_od[1]  = if_b.out_od;  assign a_od[2]  = if_c.out_od;
    assign a_alu[0] = if_a.out_alu; assign a_alu[1] = if_b.out_alu; assign a_alu[2] = if_c.out_alu;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // ---------------- reference model ----------------
    // Each FIFO is a plain list: the head is element 0, a pop shifts down, a push appends.
    int          mdepth [3] = '{16, 4, 2};
    int          mpostn [3] = '{8, 8, 1};
    logic [95:0] mf     [3][16];
    int          mcnt   [3];
    int          mst    [3];   // 0 idle, 1 armed, 2 run, 3 done
    int          mrem   [3];
    int          movf   [3];
    int          mdrop  [3];
    logic [31:0] mlast  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; mst[k] = 0; mrem[k] = 0; movf[k] = 0; mdrop[k] = 0; mlast[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        bit push;
        bit pop;
        bit dup;
        int c0;
        push = 0;
        dup  = 0;
        if (clear) begin
            mcnt[k] = 0; movf[k] = 0; mdrop[k] = 0; mst[k] = 0;
            return;
        end
        case (mst[k])
            0: if (arm) mst[k] = 1;
            1: if (pc == trig_pc) begin
                   push    = 1;
                   mrem[k] = mpostn[k] - 1;
                   mst[k]  = (mrem[k] == 0) ? 3 : 2;
               end
            2: begin
`ifdef TRACE_DEDUP_EN
                   dup = (pc == mlast[k]);
`endif
                   if (!dup) begin
                       push    = 1;
                       mrem[k] = mrem[k] - 1;
                       if (mrem[k] == 0) mst[k] = 3;
                   end
               end
            default: if (arm) mst[k] = 1;
        endcase
        c0  = mcnt[k];
        pop = (c0 > 0) && rdy[k];
        if (push) mlast[k] = pc;
        if (pop) begin
            for (int i = 0; i < 15; i++) mf[k][i] = mf[k][i+1];
            mcnt[k] = mcnt[k] - 1;
        end
        if (push) begin
            if (c0 == mdepth[k] && !pop) begin
                movf[k] = 1;
                if (mdrop[k] < 255) mdrop[k] = mdrop[k] + 1;
            end else begin
                mf[k][mcnt[k]] = {pc, od, alu};
                mcnt[k] = mcnt[k] + 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model%0d.count", k), a_cnt[k], 32'(mcnt[k]));
            chk($sformatf("model%0d.state", k), a_st[k], 32'(mst[k]));
            chk($sformatf("model%0d.overflow", k), a_ov[k], 32'(movf[k]));
            chk($sformatf("model%0d.dropped", k), a_dr[k], 32'(mdrop[k]));
            chk($sformatf("model%0d.valid", k), a_vld[k], 32'(mcnt[k] > 0));
            if (mcnt[k] > 0) begin
                chk($sformatf("model%0d.out_pc", k), a_pc[k], mf[k][0][95:64]);
                chk($sformatf("model%0d.out_od", k), a_od[k], mf[k][0][63:32]);
                chk($sformatf("model%0d.out_alu", k), a_alu[k], mf[k][0][31:0]);
            end
        end
    endtask

    task automatic chk_reset_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d.count", k), a_cnt[k], 32'd0);
            chk($sformatf("reset%0d.state", k), a_st[k], 32'd0);
            chk($sformatf("reset%0d.valid", k), a_vld[k], 32'd0);
            chk($sformatf("reset%0d.out_pc", k), a_pc[k], 32'd0);
            chk($sformatf("reset%0d.out_od", k), a_od[k], 32'd0);
            chk($sformatf("reset%0d.out_alu", k), a_alu[k], 32'd0);
            chk($sformatf("reset%0d.overflow", k), a_ov[k], 32'd0);
            chk($sformatf("reset%0d.dropped", k), a_dr[k], 32'd0);
        end
    endtask

    // One clock: advance the model with the current inputs, clock the DUTs, then compare
    task automatic cycle();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
        cmp_model();
    endtask

    task automatic drive(input bit a, input logic [31:0] p);
        arm = a;
        pc  = p;
        od  = {p[15:0], 16'hA5C3};
        alu = p + 32'h0000_1000;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          arm;
        logic [31:0] pc;
        int          rb;
        int          ca, sa;
        int          cb, sb, ob, db;
        logic [31:0] hb;
        int          cc, sc;
    } vec_t;

    vec_t tv [17];

    initial begin
        tv[0]  = '{1, 32'h00, 0, 0, 1, 0, 1, 0, 0, 32'h00, 0, 1};
        tv[1]  = '{0, 32'h00, 0, 0, 1, 0, 1, 0, 0, 32'h00, 0, 1};
        tv[2]  = '{0, 32'h04, 0, 0, 1, 0, 1, 0, 0, 32'h00, 0, 1};
        tv[3]  = '{0, 32'h08, 0, 0, 1, 0, 1, 0, 0, 32'h00, 0, 1};
        tv[4]  = '{0, 32'h0C, 0, 0, 1, 0, 1, 0, 0, 32'h00, 0, 1};
        tv[5]  = '{0, 32'h10, 0, 1, 2, 1, 2, 0, 0, 32'h10, 1, 3};
        tv[6]  = '{0, 32'h14, 0, 2, 2, 2, 2, 0, 0, 32'h10, 1, 3};
        tv[7]  = '{0, 32'h18, 0, 3, 2, 3, 2, 0, 0, 32'h10, 1, 3};
        tv[8]  = '{0, 32'h1C, 0, 4, 2, 4, 2, 0, 0, 32'h10, 1, 3};
        tv[9]  = '{0, 32'h20, 0, 5, 2, 4, 2, 1, 1, 32'h10, 1, 3};
        tv[10] = '{0, 32'h24, 0, 6, 2, 4, 2, 1, 2, 32'h10, 1, 3};
        tv[11] = '{0, 32'h28, 0, 7, 2, 4, 2, 1, 3, 32'h10, 1, 3};
        tv[12] = '{0, 32'h2C, 0, 8, 3, 4, 3, 1, 4, 32'h10, 1, 3};
        tv[13] = '{0, 32'h30, 0, 8, 3, 4, 3, 1, 4, 32'h10, 1, 3};
        tv[14] = '{1, 32'h34, 0, 8, 1, 4, 1, 1, 4, 32'h10, 1, 1};
        tv[15] = '{0, 32'h10, 1, 9, 2, 4, 2, 1, 4, 32'h14, 2, 3};
        tv[16] = '{0, 32'h200, 0, 10, 2, 4, 2, 1, 5, 32'h14, 2, 3};

        reset   = 1'b1;
        clear   = 1'b0;
        trig_pc = 32'h0000_0010;
        rdy     = 3'b000;
        drive(1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_all();
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Trigger, overflow, full push+pop and re-arm, using fixed expected values
        for (int i = 0; i < 17; i++) begin
            clear = 1'b0;
            drive(tv[i].arm != 0, tv[i].pc);
            rdy = {1'b0, tv[i].rb != 0, 1'b0};
            cycle();
            chk($sformatf("tab[%0d].A.count", i), a_cnt[0], 32'(tv[i].ca));
            chk($sformatf("tab[%0d].A.state", i), a_st[0], 32'(tv[i].sa));
            chk($sformatf("tab[%0d].A.overflow", i), a_ov[0], 32'd0);
            chk($sformatf("tab[%0d].B.count", i), a_cnt[1], 32'(tv[i].cb));
            chk($sformatf("tab[%0d].B.state", i), a_st[1], 32'(tv[i].sb));
            chk($sformatf("tab[%0d].B.overflow", i), a_ov[1], 32'(tv[i].ob));
            chk($sformatf("tab[%0d].B.dropped", i), a_dr[1], 32'(tv[i].db));
            if (tv[i].cb > 0) chk($sformatf("tab[%0d].B.head", i), a_pc[1], tv[i].hb);
            chk($sformatf("tab[%0d].C.count", i), a_cnt[2], 32'(tv[i].cc));
            chk($sformatf("tab[%0d].C.state", i), a_st[2], 32'(tv[i].sc));
        end

        // Re-arm append: drain A's 8 old entries; the re-trigger sample (pc 0x10) becomes the head
        rdy = 3'b001;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'h300 + 32'(4 * i));
            if (i == 0) chk("rearm.A.old_head", a_pc[0], 32'h10);
            cycle();
        end
        chk("rearm.A.new_head", a_pc[0], 32'h10);
        chk("rearm.A.count", a_cnt[0], 32'd8);
        rdy = 3'b000;

        // Clear in the middle of a RUN
        drive(1'b1, 32'h0);  cycle();
        drive(1'b0, 32'h10); cycle();
        drive(1'b0, 32'h14); cycle();
        clear = 1'b1;
        drive(1'b0, 32'h18); cycle();
        clear = 1'b0;
        chk("clear.A.count", a_cnt[0], 32'd0);
        chk("clear.A.state", a_st[0], 32'd0);
        chk("clear.B.overflow", a_ov[1], 32'd0);
        chk("clear.B.dropped", a_dr[1], 32'd0);

        // Asynchronous reset in the middle of a RUN
        drive(1'b1, 32'h0);  cycle();
        drive(1'b0, 32'h10); cycle();
        drive(1'b0, 32'h14); cycle();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_all();
        model_reset();
        @(negedge clk);
        reset = 1'b0;

`ifdef TRACE_DEDUP_EN
        // A pc held for three cycles in RUN yields one entry and one decrement of the countdown
        drive(1'b1, 32'h0);  cycle();
        drive(1'b0, 32'h10); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h14); cycle();
        end
        drive(1'b0, 32'h18); cycle();
        chk("dedup.A.count", a_cnt[0], 32'd3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h1C + 32'(4 * i)); cycle();
        end
        chk("dedup.A.state_run", a_st[0], 32'd2);
        drive(1'b0, 32'h2C); cycle();
        chk("dedup.A.state_done", a_st[0], 32'd3);
        chk("dedup.A.count8", a_cnt[0], 32'd8);
`endif

        // Randomized traffic checked against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [31:0] p;
            r = int'($urandom_range(0, 9));
            if (r < 3)      p = trig_pc;
            else if (r < 6) p = pc;
            else if (r < 8) p = pc + 32'd4;
            else            p = $urandom & 32'hFF;
            arm   = ($urandom_range(0, 5) == 0);
            clear = ($urandom_range(0, 49) == 0);
            pc    = p;
            od    = $urandom;
            alu   = $urandom;
            rdy   = 3'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
